// File: rtl/id_pkg.sv
// Shared decode constants, condition codes and control bundle type for the ID stage.
package id_pkg;

  localparam logic [3:0] CmdNop = 4'b0000;
  localparam logic [3:0] CmdMov = 4'b0001;
  localparam logic [3:0] CmdMvn = 4'b1001;
  localparam logic [3:0] CmdAdd = 4'b0010;
  localparam logic [3:0] CmdAdc = 4'b0011;
  localparam logic [3:0] CmdSub = 4'b0100;
  localparam logic [3:0] CmdSbc = 4'b0101;
  localparam logic [3:0] CmdAnd = 4'b0110;
  localparam logic [3:0] CmdOrr = 4'b0111;
  localparam logic [3:0] CmdEor = 4'b1000;

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpEor = 4'b0001;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpAdd = 4'b0100;
  localparam logic [3:0] OpAdc = 4'b0101;
  localparam logic [3:0] OpSbc = 4'b0110;
  localparam logic [3:0] OpTst = 4'b1000;
  localparam logic [3:0] OpCmp = 4'b1010;
  localparam logic [3:0] OpOrr = 4'b1100;
  localparam logic [3:0] OpMov = 4'b1101;
  localparam logic [3:0] OpMvn = 4'b1111;

  typedef enum logic [1:0] {
    MODE_ALU = 2'b00,
    MODE_MEM = 2'b01,
    MODE_BR  = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  typedef enum logic [3:0] {
    CondEq, CondNe, CondCs, CondCc, CondMi, CondPl, CondVs, CondVc,
    CondHi, CondLs, CondGe, CondLt, CondGt, CondLe, CondAl, CondNv
  } cond_e;

  typedef struct packed {
    logic       sUpdate;
    logic       branch;
    logic       memW;
    logic       memR;
    logic       wbEn;
    logic [3:0] exeCmd;
  } ctrl_t;

  // nzcv is ordered {N, Z, C, V}.
  function automatic logic condPass(cond_e cond, logic [3:0] nzcv);
    logic n, z, c, v;
    logic pass;
    {n, z, c, v} = nzcv;
    unique case (cond)
      CondEq: pass = z;
      CondNe: pass = ~z;
      CondCs: pass = c;
      CondCc: pass = ~c;
      CondMi: pass = n;
      CondPl: pass = ~n;
      CondVs: pass = v;
      CondVc: pass = ~v;
      CondHi: pass = c & ~z;
      CondLs: pass = ~c | z;
      CondGe: pass = (n == v);
      CondLt: pass = (n != v);
      CondGt: pass = ~z & (n == v);
      CondLe: pass = z | (n != v);
      CondAl: pass = 1'b1;
      CondNv: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/id_stage_piped_if.sv
// ID/EXE pipeline-register bundle: master is the decode stage, slave is EXE.
interface id_stage_piped_if #(
  parameter int unsigned DATA_W = 32
);
  logic              id_valid;
  logic              s_update;
  logic              branch;
  logic              mem_w;
  logic              mem_r;
  logic              wb_en_o;
  logic [3:0]        exe_cmd;
  logic [DATA_W-1:0] val_rn;
  logic [DATA_W-1:0] val_rm;
  logic [31:0]       pc_o;
  logic [23:0]       imm24;
  logic [3:0]        dest;
  logic              imm;
  logic [11:0]       shift_op;
  logic [3:0]        src1;
  logic [3:0]        src2;

  modport master (
    output id_valid, s_update, branch, mem_w, mem_r, wb_en_o, exe_cmd, val_rn, val_rm,
           pc_o, imm24, dest, imm, shift_op, src1, src2
  );

  modport slave (
    input id_valid, s_update, branch, mem_w, mem_r, wb_en_o, exe_cmd, val_rn, val_rm,
          pc_o, imm24, dest, imm, shift_op, src1, src2
  );
endinterface

// File: rtl/id_regfile.sv
// 16-entry register file: synchronous write, asynchronous dual read with optional
// same-cycle write-through and a selectable reset image.
module id_regfile #(
  parameter int unsigned DATA_W        = 32,
  parameter bit          WB_BYPASS     = 1'b1,
  parameter bit          RF_INIT_INDEX = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic [3:0]        wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [3:0]        rdAddrA,
  input  logic [3:0]        rdAddrB,
  output logic [DATA_W-1:0] rdDataA,
  output logic [DATA_W-1:0] rdDataB
);

  logic [DATA_W-1:0] regsQ [16];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        regsQ[i] <= RF_INIT_INDEX ? DATA_W'(i) : '0;
      end
    end else if (wrEn) begin
      regsQ[wrAddr] <= wrData;
    end
  end

  always_comb begin
    rdDataA = regsQ[rdAddrA];
    rdDataB = regsQ[rdAddrB];
    if (WB_BYPASS && wrEn && (wrAddr == rdAddrA)) rdDataA = wrData;
    if (WB_BYPASS && wrEn && (wrAddr == rdAddrB)) rdDataB = wrData;
  end

endmodule

// File: rtl/id_stage_piped.sv
// ARM decode stage with the ID/EXE register folded in: register read, control decode,
// condition check and RAW/load-use hazard detection feeding the freeze back to IF.
module id_stage_piped
  import id_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter bit          FWD_MODE      = 1'b1,
  parameter bit          WB_BYPASS     = 1'b1,
  parameter bit          RF_INIT_INDEX = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  input  logic [31:0]       if_pc,
  input  logic [31:0]       if_instr,
  input  logic [3:0]        status,
  input  logic              wb_en,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              exe_wb_en,
  input  logic              exe_mem_rd,
  input  logic [3:0]        exe_dest,
  input  logic              mem_wb_en,
  input  logic [3:0]        mem_dest,
  output logic              hazard,
  id_stage_piped_if.master  idExe
);

  cond_e       cond;
  mode_e       mode;
  logic        iBit, sBit;
  logic [3:0]  opcode, rnIdx, rdIdx, rmIdx, src2Idx;
  logic        isStore, twoSrc, isMovMvn, useRn, useRm;
  logic        hitExe, hitMem, rawHazard, load;
  ctrl_t       ctrl;
  logic [DATA_W-1:0] rnVal, rmVal;

  assign cond    = cond_e'(if_instr[31:28]);
  assign mode    = mode_e'(if_instr[27:26]);
  assign iBit    = if_instr[25];
  assign opcode  = if_instr[24:21];
  assign sBit    = if_instr[20];
  assign rnIdx   = if_instr[19:16];
  assign rdIdx   = if_instr[15:12];
  assign rmIdx   = if_instr[3:0];

  // Stores read the data register through the second port.
  assign isStore = (mode == MODE_MEM) && !sBit;
  assign src2Idx = isStore ? rdIdx : rmIdx;
  assign twoSrc  = !iBit || isStore;

  always_comb begin
    ctrl = '0;
    unique case (mode)
      MODE_ALU: begin
        ctrl.wbEn    = 1'b1;
        ctrl.sUpdate = sBit;
        case (opcode)
          OpMov:   ctrl.exeCmd = CmdMov;
          OpMvn:   ctrl.exeCmd = CmdMvn;
          OpAdd:   ctrl.exeCmd = CmdAdd;
          OpAdc:   ctrl.exeCmd = CmdAdc;
          OpSub:   ctrl.exeCmd = CmdSub;
          OpSbc:   ctrl.exeCmd = CmdSbc;
          OpAnd:   ctrl.exeCmd = CmdAnd;
          OpOrr:   ctrl.exeCmd = CmdOrr;
          OpEor:   ctrl.exeCmd = CmdEor;
          OpCmp: begin
            ctrl.exeCmd  = CmdSub;
            ctrl.wbEn    = 1'b0;
            ctrl.sUpdate = 1'b1;
          end
          OpTst: begin
            ctrl.exeCmd  = CmdAnd;
            ctrl.wbEn    = 1'b0;
            ctrl.sUpdate = 1'b1;
          end
          default: ctrl = '0;
        endcase
      end
      MODE_MEM: begin
        ctrl.exeCmd = CmdAdd;
        ctrl.memR   = sBit;
        ctrl.wbEn   = sBit;
        ctrl.memW   = !sBit;
      end
      MODE_BR:  ctrl.branch = 1'b1;
      MODE_RSV: ctrl.exeCmd = CmdNop;
    endcase
  end

  assign isMovMvn = (mode == MODE_ALU) && ((opcode == OpMov) || (opcode == OpMvn));
  assign useRn    = if_valid && !ctrl.branch && !isMovMvn;
  assign useRm    = if_valid && twoSrc;
  assign hitExe   = (useRn && (rnIdx == exe_dest)) || (useRm && (src2Idx == exe_dest));
  assign hitMem   = (useRn && (rnIdx == mem_dest)) || (useRm && (src2Idx == mem_dest));

  // With forwarding only a load still in EXE cannot be bypassed in time.
  assign rawHazard = FWD_MODE ? (hitExe && exe_mem_rd)
                              : ((hitExe && exe_wb_en) || (hitMem && mem_wb_en));
  assign hazard    = if_valid && !flush && rawHazard;
  assign load      = if_valid && !flush && !rawHazard && condPass(cond, status);

  id_regfile #(
    .DATA_W       (DATA_W),
    .WB_BYPASS    (WB_BYPASS),
    .RF_INIT_INDEX(RF_INIT_INDEX)
  ) uRegfile (
    .clk    (clk),
    .rst    (rst),
    .wrEn   (wb_en),
    .wrAddr (wb_dest),
    .wrData (wb_value),
    .rdAddrA(rnIdx),
    .rdAddrB(src2Idx),
    .rdDataA(rnVal),
    .rdDataB(rmVal)
  );

  logic              validD, validQ;
  ctrl_t             ctrlD, ctrlQ;
  logic [DATA_W-1:0] valRnD, valRnQ, valRmD, valRmQ;
  logic [31:0]       pcD, pcQ;
  logic [23:0]       imm24D, imm24Q;
  logic [3:0]        destD, destQ, src1D, src1Q, src2D, src2Q;
  logic              immD, immQ;
  logic [11:0]       shiftD, shiftQ;

  // Bubbles clear data fields as well so idle slots read as all-zero.
  always_comb begin
    validD = 1'b0;
    ctrlD  = '0;
    valRnD = '0;
    valRmD = '0;
    pcD    = '0;
    imm24D = '0;
    destD  = '0;
    immD   = 1'b0;
    shiftD = '0;
    src1D  = '0;
    src2D  = '0;
    if (load) begin
      validD = 1'b1;
      ctrlD  = ctrl;
      valRnD = rnVal;
      valRmD = rmVal;
      pcD    = if_pc;
      imm24D = if_instr[23:0];
      destD  = rdIdx;
      immD   = iBit;
      shiftD = if_instr[11:0];
      src1D  = rnIdx;
      src2D  = src2Idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validQ <= 1'b0;
      ctrlQ  <= '0;
      valRnQ <= '0;
      valRmQ <= '0;
      pcQ    <= '0;
      imm24Q <= '0;
      destQ  <= '0;
      immQ   <= 1'b0;
      shiftQ <= '0;
      src1Q  <= '0;
      src2Q  <= '0;
    end else begin
      validQ <= validD;
      ctrlQ  <= ctrlD;
      valRnQ <= valRnD;
      valRmQ <= valRmD;
      pcQ    <= pcD;
      imm24Q <= imm24D;
      destQ  <= destD;
      immQ   <= immD;
      shiftQ <= shiftD;
      src1Q  <= src1D;
      src2Q  <= src2D;
    end
  end

  assign idExe.id_valid = validQ;
  assign idExe.s_update = ctrlQ.sUpdate;
  assign idExe.branch   = ctrlQ.branch;
  assign idExe.mem_w    = ctrlQ.memW;
  assign idExe.mem_r    = ctrlQ.memR;
  assign idExe.wb_en_o  = ctrlQ.wbEn;
  assign idExe.exe_cmd  = ctrlQ.exeCmd;
  assign idExe.val_rn   = valRnQ;
  assign idExe.val_rm   = valRmQ;
  assign idExe.pc_o     = pcQ;
  assign idExe.imm24    = imm24Q;
  assign idExe.dest     = destQ;
  assign idExe.imm      = immQ;
  assign idExe.shift_op = shiftQ;
  assign idExe.src1     = src1Q;
  assign idExe.src2     = src2Q;

endmodule

// File: tb/tb_id_stage_piped.sv
// Bench for id_stage_piped: two configurations share one stimulus stream and are checked
// every cycle against an instruction-level model, plus literal directed expectations.
module tb_id_stage_piped;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, if_valid;
  logic [31:0] if_pc, if_instr;
  logic [3:0]  status;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic        exe_wb_en, exe_mem_rd, mem_wb_en;
  logic [3:0]  exe_dest, mem_dest;
  logic        hazA, hazB;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_stage_piped_if #(.DATA_W(32)) busA ();
  id_stage_piped_if #(.DATA_W(32)) busB ();

  id_stage_piped #(.DATA_W(32), .FWD_MODE(1'b1), .WB_BYPASS(1'b1), .RF_INIT_INDEX(1'b1)) dutA (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_pc(if_pc),
    .if_instr(if_instr), .status(status), .wb_en(wb_en), .wb_dest(wb_dest),
    .wb_value(wb_value), .exe_wb_en(exe_wb_en), .exe_mem_rd(exe_mem_rd),
    .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .hazard(hazA),
    .idExe(busA)
  );

  id_stage_piped #(.DATA_W(32), .FWD_MODE(1'b0), .WB_BYPASS(1'b0), .RF_INIT_INDEX(1'b1)) dutB (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_pc(if_pc),
    .if_instr(if_instr), .status(status), .wb_en(wb_en), .wb_dest(wb_dest),
    .wb_value(wb_value), .exe_wb_en(exe_wb_en), .exe_mem_rd(exe_mem_rd),
    .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .hazard(hazB),
    .idExe(busB)
  );

  typedef struct packed {
    logic v, s, br, mw, mr, wb;
    logic [3:0]  cmd;
    logic [31:0] rn, rm, pc;
    logic [23:0] imm24;
    logic [3:0]  dest;
    logic        imm;
    logic [11:0] sh;
    logic [3:0]  s1, s2;
  } out_t;

  out_t actA, actB, expA, expB;
  logic [31:0] rf [16];

  assign actA = {busA.id_valid, busA.s_update, busA.branch, busA.mem_w, busA.mem_r,
                 busA.wb_en_o, busA.exe_cmd, busA.val_rn, busA.val_rm, busA.pc_o,
                 busA.imm24, busA.dest, busA.imm, busA.shift_op, busA.src1, busA.src2};
  assign actB = {busB.id_valid, busB.s_update, busB.branch, busB.mem_w, busB.mem_r,
                 busB.wb_en_o, busB.exe_cmd, busB.val_rn, busB.val_rm, busB.pc_o,
                 busB.imm24, busB.dest, busB.imm, busB.shift_op, busB.src1, busB.src2};

  task automatic chk(string name, logic [159:0] got, logic [159:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // ---- instruction-level reference model ----
  function automatic int aluCmd(logic [3:0] op);
    case (op)
      4'd13: return 1;  4'd15: return 9;  4'd4: return 2;  4'd5: return 3;
      4'd2:  return 4;  4'd6:  return 5;  4'd0: return 6;  4'd12: return 7;
      4'd1:  return 8;  4'd10: return 4;  4'd8: return 6;
      default: return -1;
    endcase
  endfunction

  function automatic bit condOk(logic [3:0] c, logic [3:0] f);
    bit n = f[3], z = f[2], cy = f[1], v = f[0];
    case (c)
      0: return z;          1: return !z;        2: return cy;       3: return !cy;
      4: return n;          5: return !n;        6: return v;        7: return !v;
      8: return cy && !z;   9: return !cy || z;  10: return n == v;  11: return n != v;
      12: return !z && n == v;  13: return z || n != v;  14: return 1;  default: return 0;
    endcase
  endfunction

  function automatic bit predHaz(bit fwd);
    logic [1:0] md = if_instr[27:26];
    logic [3:0] op = if_instr[24:21];
    logic [3:0] rn = if_instr[19:16];
    bit isStr = (md == 1) && !if_instr[20];
    logic [3:0] s2 = isStr ? if_instr[15:12] : if_instr[3:0];
    bit rnUsed = (md != 2) && !((md == 0) && (op == 13 || op == 15));
    bit rmUsed = !if_instr[25] || isStr;
    bit he = (rnUsed && rn == exe_dest) || (rmUsed && s2 == exe_dest);
    bit hm = (rnUsed && rn == mem_dest) || (rmUsed && s2 == mem_dest);
    if (!if_valid || flush) return 0;
    if (fwd) return he && exe_mem_rd;
    return (he && exe_wb_en) || (hm && mem_wb_en);
  endfunction

  function automatic logic [31:0] rdReg(logic [3:0] idx, bit byp);
    return (byp && wb_en && wb_dest == idx) ? wb_value : rf[idx];
  endfunction

  function automatic out_t predict(bit fwd, bit byp);
    out_t o = '0;
    logic [1:0] md = if_instr[27:26];
    logic [3:0] op = if_instr[24:21];
    bit sb = if_instr[20];
    bit isStr = (md == 1) && !sb;
    int cmd;
    if (!if_valid || flush || predHaz(fwd) || !condOk(if_instr[31:28], status)) return o;
    o.v = 1;
    if (md == 0) begin
      cmd = aluCmd(op);
      if (cmd >= 0) begin
        o.cmd = 4'(cmd);
        o.s   = sb || op == 10 || op == 8;
        o.wb  = !(op == 10 || op == 8);
      end
    end else if (md == 1) begin
      o.cmd = 4'd2;
      o.mr  = sb;
      o.wb  = sb;
      o.mw  = !sb;
    end else if (md == 2) begin
      o.br = 1;
    end
    o.s1    = if_instr[19:16];
    o.s2    = isStr ? if_instr[15:12] : if_instr[3:0];
    o.rn    = rdReg(o.s1, byp);
    o.rm    = rdReg(o.s2, byp);
    o.pc    = if_pc;
    o.imm24 = if_instr[23:0];
    o.dest  = if_instr[15:12];
    o.imm   = if_instr[25];
    o.sh    = if_instr[11:0];
    return o;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) rf[i] = i;
      expA = '0;
      expB = '0;
    end else begin
      expA = predict(1'b1, 1'b1);
      expB = predict(1'b0, 1'b0);
      if (wb_en) rf[wb_dest] = wb_value;
    end
  end

  always @(negedge clk) begin
    chk("hazA", hazA, predHaz(1'b1));
    chk("hazB", hazB, predHaz(1'b0));
    chk("outsA", actA, rst ? expA : out_t'('0));
    chk("outsB", actB, rst ? expB : out_t'('0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    logic [31:0] w = $urandom;
    w[31:28] = ($urandom_range(3) == 0) ? 4'($urandom) : 4'he;
    w[19:16] = 4'($urandom_range(3));
    w[15:12] = 4'($urandom_range(3));
    w[3:0]   = 4'($urandom_range(3));
    if_instr   = w;
    if_pc      = $urandom;
    if_valid   = ($urandom_range(7) != 0);
    flush      = ($urandom_range(9) == 0);
    status     = 4'($urandom);
    wb_en      = $urandom_range(1);
    wb_dest    = 4'($urandom_range(3));
    wb_value   = $urandom;
    exe_wb_en  = $urandom_range(1);
    exe_mem_rd = $urandom_range(1);
    exe_dest   = 4'($urandom_range(3));
    mem_wb_en  = $urandom_range(1);
    mem_dest   = 4'($urandom_range(3));
  endtask

  initial begin
    rst = 1'b0; flush = 0; if_valid = 0; if_pc = 0; if_instr = 0; status = 0;
    wb_en = 0; wb_dest = 0; wb_value = 0; exe_wb_en = 0; exe_mem_rd = 0; exe_dest = 0;
    mem_wb_en = 0; mem_dest = 0;
    repeat (3) step();
    chk("rst_valid", busA.id_valid, 0);
    chk("rst_cmd", busA.exe_cmd, 0);

    // ADD R1,R2,R3 right after reset release
    rst = 1; if_valid = 1; if_pc = 32'h4; if_instr = 32'hE0821003;
    step();
    chk("add_rn", busA.val_rn, 32'd2);
    chk("add_rm", busA.val_rm, 32'd3);
    chk("add_cmd", busA.exe_cmd, 4'b0010);
    chk("add_wb", busA.wb_en_o, 1);
    chk("add_valid", busA.id_valid, 1);

    wb_en = 1; wb_dest = 2; wb_value = 32'h55;
    step();
    chk("byp_on", busA.val_rn, 32'h55);
    chk("byp_off", busB.val_rn, 32'd2);
    wb_en = 0;

    exe_mem_rd = 1; exe_dest = 3;
    #1 chk("loaduse_haz", hazA, 1);
    step();
    chk("loaduse_bubble", busA.id_valid, 0);
    exe_mem_rd = 0;
    #1 chk("noload_haz", hazA, 0);
    step();
    chk("redecode_valid", busA.id_valid, 1);

    mem_wb_en = 1; mem_dest = 2; if_instr = 32'hE3A01005;
    #1 chk("mov_nohaz", hazB, 0);
    if_instr = 32'hE2821001;
    #1 chk("raw_mem_haz", hazB, 1);
    chk("raw_fwd_nohaz", hazA, 0);
    step();
    mem_wb_en = 0;

    status = 4'b0000; if_instr = 32'h00821003;
    #1 chk("eq_nohaz", hazA, 0);
    step();
    chk("eq_false", busA.id_valid, 0);
    status = 4'b0100;
    step();
    chk("eq_true", busA.id_valid, 1);

    exe_mem_rd = 1; exe_dest = 3; if_instr = 32'hE0821003; flush = 1;
    #1 chk("flush_haz", hazA, 0);
    step();
    chk("flush_bubble", busA.id_valid, 0);
    flush = 0; exe_mem_rd = 0;
    step();
    chk("post_flush", busA.id_valid, 1);

    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        #2 rst = 0;
        step();
        rst = 1;
      end
      randomize_inputs();
      step();
    end
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_stage_piped.md
Name: id_stage_piped

Overview:
Parametrised decode stage for the ARM pipeline: the successor to the combinational decode stage, with the ID/EXE pipeline register folded in. It contains the register file with same-cycle WB→read bypass, control decode, condition check, and load-use/RAW hazard detection with a selectable forwarding mode. It sits between the IF/ID register and EXE, and drives the freeze signal back to IF.

Parameters:
DATA_W, 32, register and result width (≥8)
FWD_MODE, 1, 1 = forwarding unit present (stall only on load-use); 0 = stall on any RAW against EXE/MEM
WB_BYPASS, 1, 1 = same-cycle WB write visible to ID read; 0 = old value read
RF_INIT_INDEX, 1, 1 = register i resets to i; 0 = all registers reset to 0

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous reset, active-low
flush  in  1  branch taken: discard the current decode
if_valid  in  1  IF/ID holds a real instruction
if_pc  in  32  PC+4 from IF
if_instr  in  32  instruction word
status  in  4  NZCV from status register
wb_en  in  1  WB write enable
wb_dest  in  4  WB register index
wb_value  in  DATA_W  WB data
exe_wb_en, exe_mem_rd  in  1  EXE-stage instruction writes back / is a load
exe_dest  in  4  EXE destination
mem_wb_en  in  1  MEM-stage instruction writes back
mem_dest  in  4  MEM destination
hazard  out  1  combinational; freezes PC and IF/ID
id_valid  out  1  registered; ID/EXE slot holds a live instruction
s_update, branch, mem_w, mem_r, wb_en_o  out  1  registered controls
exe_cmd  out  4  registered ALU command
val_rn, val_rm  out  DATA_W  registered operand values
pc_o  out  32  registered PC
imm24  out  24  registered branch offset
dest  out  4  registered Rd
imm  out  1  registered I bit
shift_op  out  12  registered shifter operand
src1, src2  out  4  registered source indices (for forwarding unit)

Behaviour:
- Fields: cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], shift[11:0], Rm[3:0].
- src2 = Rd when the instruction is a store, else Rm. two_src = ~I | store.
- Decode, mode 00: MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011, SUB 0010→0100, SBC 0110→0101, AND 0000→0110, ORR 1100→0111, EOR 0001→1000, CMP 1010→0100, TST 1000→0110.
  - wb_en for all mode-00 ops except CMP/TST. s_update = S; CMP/TST always s_update=1.
  - Unlisted opcodes decode to a NOP with all controls 0.
- Decode, mode 01: exe_cmd 0010. S=1 is LDR (mem_r, wb_en); S=0 is STR (mem_w).
- Decode, mode 10: branch=1, all other controls 0. Mode 11 decodes to a NOP.
- Condition check: 16 ARM codes EQ..AL on NZCV; 1111 evaluates false.
- Hazard check:
  - use_rn = valid ∧ ¬branch ∧ ¬MOV ∧ ¬MVN; use_rm = valid ∧ two_src.
  - FWD_MODE=0: hazard if a used source equals exe_dest with exe_wb_en, or equals mem_dest with mem_wb_en.
  - FWD_MODE=1: hazard only on a used-source match with exe_dest ∧ exe_mem_rd.
  - hazard is forced 0 when flush=1 or if_valid=0.
- Register file:
  - 16×DATA_W, written at posedge clk when wb_en.
  - Read is asynchronous. With WB_BYPASS=1, a read whose index equals wb_dest while wb_en=1 returns wb_value.
- ID/EXE register, priority order:
  - rst low: all outputs 0, id_valid 0, RF initialised per RF_INIT_INDEX.
  - flush: bubble (all controls 0, id_valid 0).
  - hazard: bubble; IF holds, so the instruction is re-decoded next cycle.
  - condition false or if_valid=0: bubble; the instruction is consumed.
  - otherwise load decoded values, id_valid 1.
- Bubble rule: controls are zeroed; data fields are also cleared to 0 for deterministic waveforms.
- Latency: one cycle from if_instr to registered outputs.
- Reset asserted mid-stream clears the slot immediately and asynchronously. The first instruction after reset release is captured on the first posedge with rst high.

Decomposition:
- Package id_pkg: exe_cmd constants, mode codes (MODE_ALU/MEM/BR), opcode constants, condition-code constants, and a decoded-control struct typedef.
- One sub-module: id_regfile (16×DATA_W, async read, bypass and init parameters).
- Decode, condition check and hazard logic stay inline.

Test Plan:
- Reset: RF_INIT_INDEX=1, hold rst low, then decode ADD R1,R2,R3 (0xE0821003) → next cycle val_rn=2, val_rm=3, exe_cmd=0010, wb_en_o=1, id_valid=1.
- WB bypass: wb_en=1, wb_dest=2, wb_value=0x55 in the same cycle as decoding ADD R1,R2,R3 → val_rn=0x55 with WB_BYPASS=1; val_rn=2 with WB_BYPASS=0.
- Load-use, FWD_MODE=1: exe_mem_rd=1, exe_dest=3, decode ADD R1,R2,R3 → hazard=1, bubble inserted. With exe_mem_rd=0 → hazard=0.
- FWD_MODE=0: mem_wb_en=1, mem_dest=2, decode MOV R1,#5 → hazard=0 (Rn unused). Decode ADD R1,R2,#1 → hazard=1.
- Condition: status Z=0, decode ADDEQ → id_valid=0 and hazard=0 with no stall. Set Z=1 → id_valid=1.
- Flush priority: flush=1 together with a hazard-causing LDR dependency → hazard=0, bubble, and next-cycle instruction proceeds.
